// File: rtl/mcu_pkg.sv
// Shared definitions for the microcontroller core: opcodes, unit indices,
// sequencer state encoding and instruction field positions.
package mcu_pkg;

  // Opcodes carried in IR[15:12]; anything not listed is illegal.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOVI = 4'h1;
  localparam logic [3:0] OP_MOV  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hF;

  // Execution unit indices into start/done.
  localparam int unsigned NUM_UNITS = 4;
  localparam int unsigned UNIT_MOVI = 0;
  localparam int unsigned UNIT_MOV  = 1;
  localparam int unsigned UNIT_ADD  = 2;
  localparam int unsigned UNIT_JMP  = 3;

  // Instruction field slices.
  localparam int unsigned IR_OP_MSB = 15;
  localparam int unsigned IR_OP_LSB = 12;
  localparam int unsigned IR_P1_MSB = 11;
  localparam int unsigned IR_P1_LSB = 6;
  localparam int unsigned IR_P2_MSB = 5;
  localparam int unsigned IR_P2_LSB = 0;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StRetire = 3'd4,
    StHalt   = 3'd5
  } state_e;

endpackage

// File: rtl/instr_decode.sv
// Opcode classifier: one-hot execution unit, or nop / halt / illegal.
module instr_decode
  import mcu_pkg::*;
(
  input  logic [3:0]           opcode_i,
  output logic [NUM_UNITS-1:0] unit_o,
  output logic                 nop_o,
  output logic                 halt_o,
  output logic                 illegal_o
);

  // Exactly one of unit_o/nop_o/halt_o/illegal_o is active for any opcode.
  always_comb begin
    unit_o    = '0;
    nop_o     = 1'b0;
    halt_o    = 1'b0;
    illegal_o = 1'b0;
    case (opcode_i)
      OP_MOVI: unit_o[UNIT_MOVI] = 1'b1;
      OP_MOV:  unit_o[UNIT_MOV]  = 1'b1;
      OP_ADD:  unit_o[UNIT_ADD]  = 1'b1;
      OP_JMP:  unit_o[UNIT_JMP]  = 1'b1;
      OP_NOP:  nop_o             = 1'b1;
      OP_HALT: halt_o            = 1'b1;
      default: illegal_o         = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/dispatch controller. Hands each instruction to at most one
// execution unit through a held start/done handshake, then retires it with a
// donefetch pulse and advances (or branches) the PC.
module instr_sequencer
  import mcu_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            pm_req,
  output logic [PC_W-1:0] pm_addr,
  input  logic            pm_ack,
  input  logic [15:0]     pm_data,
  output logic [5:0]      parameter1,
  output logic [5:0]      parameter2,
  output logic [3:0]      start,
  input  logic [3:0]      done,
  output logic            donefetch,
  input  logic            pc_load,
  input  logic [PC_W-1:0] pc_load_val,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            err_illegal,
  output logic            err_timeout
);

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [PC_W-1:0]        tgt_q, tgt_d;
  logic [15:0]            ir_q, ir_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   jmp_q, jmp_d;
  logic                   err_tmo_q, err_tmo_d;

  logic [NUM_UNITS-1:0]   unit;
  logic                   is_nop, is_halt, is_illegal;
  logic                   done_hit, tmo_hit;

  instr_decode u_decode (
    .opcode_i  (ir_q[IR_OP_MSB:IR_OP_LSB]),
    .unit_o    (unit),
    .nop_o     (is_nop),
    .halt_o    (is_halt),
    .illegal_o (is_illegal)
  );

  // Only the dispatched unit's done is honoured.
  assign done_hit = |(done & unit);
  assign tmo_hit  = (cnt_q == TmoLast);

  assign pm_addr     = pc_q;
  assign pc          = pc_q;
  assign parameter1  = ir_q[IR_P1_MSB:IR_P1_LSB];
  assign parameter2  = ir_q[IR_P2_MSB:IR_P2_LSB];
  assign busy        = (state_q != StIdle) && (state_q != StHalt);
  assign halted      = (state_q == StHalt);
  assign err_timeout = err_tmo_q;

  // State and datapath registers; start/donefetch are decoded from state_q so
  // they drop as soon as reset asserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      pc_q      <= '0;
      tgt_q     <= '0;
      ir_q      <= '0;
      cnt_q     <= '0;
      jmp_q     <= 1'b0;
      err_tmo_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      jmp_q     <= jmp_d;
      err_tmo_q <= err_tmo_d;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    ir_d        = ir_q;
    cnt_d       = cnt_q;
    jmp_d       = jmp_q;
    err_tmo_d   = 1'b0;
    pm_req      = 1'b0;
    start       = '0;
    donefetch   = 1'b0;
    err_illegal = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        // An outstanding request is completed even if run drops.
        pm_req = 1'b1;
        if (pm_ack) begin
          ir_d    = pm_data;
          state_d = StDecode;
        end
      end
      StDecode: begin
        jmp_d = 1'b0;
        if (is_halt) begin
          state_d = StHalt;
        end else if (is_nop) begin
          state_d = StRetire;
        end else if (is_illegal) begin
          err_illegal = 1'b1;
          state_d     = StRetire;
        end else begin
          cnt_d   = '0;
          state_d = StExec;
        end
      end
      StExec: begin
        start = unit;
        // Branch target is captured on any EXEC cycle, including the done cycle.
        if (unit[UNIT_JMP] && pc_load) begin
          jmp_d = 1'b1;
          tgt_d = pc_load_val;
        end
        if (done_hit) begin
          state_d = StRetire;
        end else if (tmo_hit) begin
          err_tmo_d = 1'b1;
          state_d   = StRetire;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StRetire: begin
        donefetch = 1'b1;
        pc_d      = jmp_q ? tgt_q : pc_q + 1'b1;
        state_d   = run ? StFetch : StIdle;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: an instruction-level model expands each
// instruction into its expected per-cycle outputs, and a negedge process
// compares the DUT against those expectations.
module tb_instr_sequencer;

  localparam int PC_W    = 8;
  localparam int TIMEOUT = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            run;
  logic            pm_req;
  logic [PC_W-1:0] pm_addr;
  logic            pm_ack;
  logic [15:0]     pm_data;
  logic [5:0]      parameter1, parameter2;
  logic [3:0]      start;
  logic [3:0]      done;
  logic            donefetch;
  logic            pc_load;
  logic [PC_W-1:0] pc_load_val;
  logic [PC_W-1:0] pc;
  logic            busy, halted, err_illegal, err_timeout;

  instr_sequencer #(
    .PC_W    (PC_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .pm_req      (pm_req),
    .pm_addr     (pm_addr),
    .pm_ack      (pm_ack),
    .pm_data     (pm_data),
    .parameter1  (parameter1),
    .parameter2  (parameter2),
    .start       (start),
    .done        (done),
    .donefetch   (donefetch),
    .pc_load     (pc_load),
    .pc_load_val (pc_load_val),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;

  // Architectural model state.
  logic [7:0] m_pc;
  logic [5:0] m_p1, m_p2;

  // Expected outputs for the current cycle.
  bit         chk_en = 1'b0;
  logic       e_req, e_df, e_ill, e_tmo, e_busy, e_halt;
  logic [3:0] e_start;
  logic [7:0] e_pc;
  logic [5:0] e_p1, e_p2;

  // Event monitors used by the literal checks.
  int         start_hi_cnt = 0;
  int         rise_cyc = 0;
  int         tmo_cyc = 0;
  int         ill_cnt = 0;
  logic [3:0] start_prev = 4'd0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  always @(posedge clk) cyc_n++;

  // Single compare process against the model's per-cycle expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pm_req", int'(pm_req), int'(e_req));
      if (e_req) check("pm_addr", int'(pm_addr), int'(e_pc));
      check("start", int'(start), int'(e_start));
      check("donefetch", int'(donefetch), int'(e_df));
      check("err_illegal", int'(err_illegal), int'(e_ill));
      check("err_timeout", int'(err_timeout), int'(e_tmo));
      check("busy", int'(busy), int'(e_busy));
      check("halted", int'(halted), int'(e_halt));
      check("pc", int'(pc), int'(e_pc));
      check("parameter1", int'(parameter1), int'(e_p1));
      check("parameter2", int'(parameter2), int'(e_p2));
    end
    if (start != 4'd0) begin
      start_hi_cnt++;
      if (start_prev == 4'd0) rise_cyc = cyc_n;
    end
    start_prev = start;
    if (err_timeout) tmo_cyc = cyc_n;
    if (err_illegal) ill_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic req, input logic [3:0] st, input logic df, input logic ill,
                         input logic tmo, input logic bsy, input logic hlt);
    e_req = req; e_start = st; e_df = df; e_ill = ill; e_tmo = tmo;
    e_busy = bsy; e_halt = hlt; e_pc = m_pc; e_p1 = m_p1; e_p2 = m_p2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      run = 1'b0;
      set_exp(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  task automatic go();
    run = 1'b1;
    set_exp(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  function automatic logic [15:0] rand_word();
    logic [3:0] op;
    case ($urandom_range(0, 9))
      0:       op = 4'h0;
      1, 2:    op = 4'h1;
      3, 4:    op = 4'h2;
      5, 6:    op = 4'h3;
      default: op = 4'($urandom_range(5, 14));
    endcase
    return {op, 12'($urandom)};
  endfunction

  // Runs one instruction starting in FETCH. done_dly: EXEC cycle (from 0) on
  // which the unit raises done, -1 for never. load_cyc: EXEC cycle with
  // pc_load for a jmp, -1 for none. abort_at: return mid-EXEC on that cycle.
  task automatic do_instr(input logic [15:0] w, input int ack_wait, input int done_dly,
                          input int load_cyc, input logic [7:0] load_val, input bit cont,
                          input int abort_at);
    logic [3:0] op;
    bit         ill, taken, tmo, fin, hit;
    logic [7:0] tgt;
    int         k, c;
    op    = w[15:12];
    ill   = !(op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hF});
    taken = 1'b0; tmo = 1'b0; fin = 1'b0; tgt = 8'd0;
    for (int i = 0; i <= ack_wait; i++) begin
      pm_ack      = (i == ack_wait);
      pm_data     = pm_ack ? w : 16'($urandom);
      run         = 1'($urandom);
      done        = 4'($urandom);
      pc_load     = 1'($urandom);
      pc_load_val = 8'($urandom);
      set_exp(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    m_p1 = w[11:6];
    m_p2 = w[5:0];
    pm_ack  = 1'b0;
    pm_data = 16'($urandom);
    set_exp(1'b0, 4'd0, 1'b0, ill, 1'b0, 1'b1, 1'b0);
    tick();
    if (op == 4'hF) return;
    if (op >= 4'h1 && op <= 4'h4) begin
      k = int'(op) - 1;
      c = 0;
      while (!fin) begin
        hit     = (done_dly >= 0) && (c >= done_dly);
        done    = 4'($urandom);
        done[k] = hit;
        run     = 1'($urandom);
        if (k == 3) begin
          pc_load     = (c == load_cyc);
          pc_load_val = (c == load_cyc) ? load_val : 8'($urandom);
          if (c == load_cyc) begin
            taken = 1'b1;
            tgt   = load_val;
          end
        end else begin
          pc_load     = 1'($urandom);
          pc_load_val = 8'($urandom);
        end
        set_exp(1'b0, 4'(1 << k), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        if (c == abort_at) return;
        tick();
        if (hit) begin
          fin = 1'b1;
        end else if (c == TIMEOUT - 1) begin
          fin = 1'b1;
          tmo = 1'b1;
        end
        c++;
      end
    end
    run         = cont;
    done        = 4'($urandom);
    pc_load     = 1'($urandom);
    pc_load_val = 8'($urandom);
    set_exp(1'b0, 4'd0, 1'b1, 1'b0, tmo, 1'b1, 1'b0);
    tick();
    m_pc = taken ? tgt : m_pc + 8'd1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pc0;
    rst = 1'b0; run = 1'b0; pm_ack = 1'b0; pm_data = 16'd0;
    done = 4'd0; pc_load = 1'b0; pc_load_val = 8'd0;
    m_pc = 8'd0; m_p1 = 6'd0; m_p2 = 6'd0;
    tick(); tick();

    // Reset state.
    check("rst_pc", int'(pc), 0);
    check("rst_start", int'(start), 0);
    check("rst_pm_req", int'(pm_req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_donefetch", int'(donefetch), 0);
    check("rst_params", int'({parameter1, parameter2}), 0);
    check("rst_errs", int'({err_illegal, err_timeout}), 0);
    rst = 1'b1;
    set_exp(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    idle(2);

    // movi 0x10C5 at address 0, done one cycle after start.
    go();
    start_hi_cnt = 0;
    do_instr(16'h10C5, 0, 1, -1, 8'd0, 1'b1, -1);
    check("movi_start_cycles", start_hi_cnt, 2);
    check("movi_p1", int'(parameter1), 3);
    check("movi_p2", int'(parameter2), 5);
    check("movi_pc", int'(pc), 1);

    // Non-branch instructions up to pc=7, then a jmp with load in the done cycle.
    while (m_pc != 8'd7) do_instr(rand_word(), $urandom_range(0, 3), $urandom_range(0, 4),
                                  -1, 8'd0, 1'b1, -1);
    begin
      int dd;
      dd = $urandom_range(0, 3);
      do_instr({4'h4, 12'($urandom)}, $urandom_range(0, 2), dd, dd, 8'h20, 1'b1, -1);
    end
    check("jmp_pc", int'(pc), 32'h20);
    check("jmp_pm_req", int'(pm_req), 1);
    check("jmp_pm_addr", int'(pm_addr), 32'h20);

    // Illegal opcode.
    ill_cnt = 0; start_hi_cnt = 0;
    do_instr(16'h9ABC, 0, 0, -1, 8'd0, 1'b1, -1);
    check("ill_pulses", ill_cnt, 1);
    check("ill_no_start", start_hi_cnt, 0);
    check("ill_pc", int'(pc), 32'h21);

    // Randomised mix including jmps, timeouts and idle gaps.
    for (int n = 0; n < 40; n++) begin
      int          sel, dd, lc;
      bit          cnt;
      logic [15:0] w;
      sel = $urandom_range(0, 11);
      cnt = ($urandom_range(0, 3) != 0);
      dd  = $urandom_range(0, 4);
      lc  = -1;
      if (sel < 8) begin
        w = rand_word();
      end else if (sel < 11) begin
        w = {4'h4, 12'($urandom)};
        if ($urandom_range(0, 1) == 1) lc = $urandom_range(0, dd);
      end else begin
        w  = {4'($urandom_range(1, 4)), 12'($urandom)};
        dd = -1;
      end
      do_instr(w, $urandom_range(0, 3), dd, lc, 8'($urandom), cnt, -1);
      if (!cnt) begin
        idle($urandom_range(0, 3));
        go();
      end
    end

    // add with no done: timeout exactly TIMEOUT cycles after start rose.
    pc0 = m_pc;
    do_instr(16'h3041, 0, -1, -1, 8'd0, 1'b1, -1);
    check("tmo_latency", tmo_cyc - rise_cyc, 32);
    check("tmo_pc", int'(pc), int'(pc0 + 8'd1));

    // Reset asserted mid-EXEC drops start without waiting for a clock.
    do_instr(16'h1123, 0, -1, -1, 8'd0, 1'b1, 2);
    check("pre_rst_start", int'(start), 1);
    chk_en = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("async_rst_start", int'(start), 0);
    check("async_rst_donefetch", int'(donefetch), 0);
    check("async_rst_busy", int'(busy), 0);
    tick(); tick();
    m_pc = 8'd0; m_p1 = 6'd0; m_p2 = 6'd0;
    run = 1'b0;
    rst = 1'b1;
    set_exp(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    idle(1);

    // PC wraps from 0xFF to 0x00.
    go();
    do_instr(16'h4000, 0, 0, 0, 8'hFF, 1'b1, -1);
    check("wrap_pre_pc", int'(pc), 32'hFF);
    do_instr(16'h0000, 1, 0, -1, 8'd0, 1'b1, -1);
    check("wrap_pc", int'(pc), 0);

    // Halt: no further fetches while run stays high.
    do_instr(16'hF123, 1, 0, -1, 8'd0, 1'b1, -1);
    for (int i = 0; i < 8; i++) begin
      run = 1'($urandom);
      set_exp(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    check("halt_halted", int'(halted), 1);
    check("halt_pm_req", int'(pm_req), 0);
    check("halt_p1", int'(parameter1), 4);
    check("halt_p2", int'(parameter2), 32'h23);
    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    check("halt_rst_halted", int'(halted), 0);
    tick();
    rst = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
